fft64_ctrl: RTL and testbench

FFT64_CTRL -- requirements
Module: fft64_ctrl

---
 rtl/fft64_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fft64_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft64_ctrl.sv
// fft64_ctrl: sequencer for a 64-point FFT built from two passes of eight
// 8-point core operations (column pass, then row pass).
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   start         : one-cycle request to begin a transform (IDLE only)
//   abort         : cancel a transform in progress
//   core_vld_out  : result-valid strobe returned by the 8-point core
//   busy          : transform in progress (read or drain phase)
//   done          : one-cycle pulse after the row pass completes
//   pass          : 0 = column pass, 1 = row pass
//   rd_en/rd_grp  : sample-buffer read strobe and group index
//   core_vld_in   : core valid-in, rd_en delayed RD_LAT cycles
//   tw_grp        : twiddle-ROM group index, rd_grp delayed RD_LAT cycles
//   wr_en/wr_grp  : result write strobe and group index
//   err           : sticky protocol-error flag, cleared only by rst
module fft64_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned GRP_WD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              core_vld_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              rd_en,
  output logic [GRP_WD-1:0] rd_grp,
  output logic              core_vld_in,
  output logic [GRP_WD-1:0] tw_grp,
  output logic              wr_en,
  output logic [GRP_WD-1:0] wr_grp,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_DR0,
    S_RD1,
    S_DR1,
    S_DONE
  } state_t;

  // Core results still in flight after an abort are swallowed for this long.
  localparam logic [2:0] IGN_LEN = 3'(RD_LAT + 2);

  state_t              state_q, state_d;
  logic [GRP_WD-1:0]   rd_cnt_q, rd_cnt_d;
  logic [GRP_WD-1:0]   wr_cnt_q, wr_cnt_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [2:0]          ign_q, ign_d;
  logic [RD_LAT-1:0]   pipe_en_q, pipe_en_d;
  logic [GRP_WD-1:0]   pipe_grp_q [RD_LAT];
  logic [GRP_WD-1:0]   pipe_grp_d [RD_LAT];

  logic is_rd, is_dr, ign_act, wr_ok, last_wr;

  always_comb begin
    is_rd   = (state_q == S_RD0) || (state_q == S_RD1);
    is_dr   = (state_q == S_DR0) || (state_q == S_DR1);
    ign_act = (ign_q != '0);
    // full_q marks a pass whose eight writes already landed while still reading.
    wr_ok   = core_vld_out && !ign_act && (is_rd || is_dr) && !full_q;
    last_wr = wr_ok && (wr_cnt_q == '1);
  end

  always_comb begin
    busy        = is_rd || is_dr;
    done        = (state_q == S_DONE) && !abort;
    pass        = (state_q == S_RD1) || (state_q == S_DR1);
    rd_en       = is_rd;
    rd_grp      = rd_cnt_q;
    core_vld_in = pipe_en_q[RD_LAT-1];
    tw_grp      = pipe_grp_q[RD_LAT-1];
    wr_en       = wr_ok;
    wr_grp      = wr_cnt_q;
    err         = err_q;
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    full_d   = full_q;
    err_d    = err_q;
    ign_d    = ign_act ? ign_q - 3'd1 : '0;

    pipe_en_d[0]  = is_rd;
    pipe_grp_d[0] = rd_cnt_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_en_d[i]  = pipe_en_q[i-1];
      pipe_grp_d[i] = pipe_grp_q[i-1];
    end

    if (core_vld_out && !ign_act && !wr_ok) begin
      err_d = 1'b1;
    end

    if (wr_ok) begin
      wr_cnt_d = wr_cnt_q + GRP_WD'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RD0;
        end
      end
      S_RD0, S_RD1: begin
        rd_cnt_d = rd_cnt_q + GRP_WD'(1);
        if (last_wr) begin
          full_d = 1'b1;
        end
        if (rd_cnt_q == '1) begin
          state_d = (state_q == S_RD0) ? S_DR0 : S_DR1;
        end
      end
      S_DR0, S_DR1: begin
        if (full_q || last_wr) begin
          state_d  = (state_q == S_DR0) ? S_RD1 : S_DONE;
          wr_cnt_d = '0;
          full_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      full_d    = 1'b0;
      ign_d     = IGN_LEN;
      pipe_en_d = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_grp_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      ign_q     <= '0;
      pipe_en_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_grp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
      ign_q     <= ign_d;
      pipe_en_q <= pipe_en_d;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_grp_q[i] <= pipe_grp_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fft64_ctrl.sv
// Bench for fft64_ctrl: RD_LAT=1 instance checked every cycle against a
// transaction-level model, plus literal timing checks; an RD_LAT=3 instance
// checked with literal timing expectations.
module tb_fft64_ctrl;

  localparam int M_LAT = 1;

  logic clk;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  // RD_LAT = 1 instance
  logic       rst, start, abort, inj;
  logic       core_vld_out;
  logic       busy, done, pass, rd_en, core_vld_in, wr_en, err;
  logic [2:0] rd_grp, tw_grp, wr_grp;
  logic       d1, d2;

  // RD_LAT = 3 instance
  logic       rst3, start3, core_vld_out3;
  logic       busy3, done3, pass3, rd_en3, core_vld_in3, wr_en3, err3;
  logic [2:0] rd_grp3, tw_grp3, wr_grp3;
  logic       e1, e2;

  fft64_ctrl #(.RD_LAT(1), .GRP_WD(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .core_vld_out(core_vld_out), .busy(busy), .done(done), .pass(pass),
    .rd_en(rd_en), .rd_grp(rd_grp), .core_vld_in(core_vld_in),
    .tw_grp(tw_grp), .wr_en(wr_en), .wr_grp(wr_grp), .err(err)
  );

  fft64_ctrl #(.RD_LAT(3), .GRP_WD(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .abort(1'b0),
    .core_vld_out(core_vld_out3), .busy(busy3), .done(done3), .pass(pass3),
    .rd_en(rd_en3), .rd_grp(rd_grp3), .core_vld_in(core_vld_in3),
    .tw_grp(tw_grp3), .wr_en(wr_en3), .wr_grp(wr_grp3), .err(err3)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // 8-point core stand-ins: valid returns two cycles after valid-in.
  always @(posedge clk) begin
    d1 <= core_vld_in;
    d2 <= d1;
    e1 <= core_vld_in3;
    e2 <= e1;
  end
  assign core_vld_out  = d2 | inj;
  assign core_vld_out3 = e2;

  // Recorded outputs, indexed by cycle
  logic       h_busy[512], h_done[512], h_pass[512], h_rd[512];
  logic       h_cvi[512], h_wr[512], h_err[512];
  logic [2:0] h_rdg[512], h_wrg[512];
  logic       h3_rd[512], h3_cvi[512], h3_wr[512], h3_done[512];

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 reading, 2 draining, 3 done.
  int m_phase = 0, m_pass = 0, m_nread = 0, m_nwrite = 0, m_quiet = 0;
  int m_err = 0;
  int q_en[$];
  int q_grp[$];

  task automatic model_clear_pipe();
    q_en.delete();
    q_grp.delete();
    for (int i = 0; i < M_LAT; i++) begin
      q_en.push_back(0);
      q_grp.push_back(0);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin : model_step
      int busy_e, done_e, pass_e, rd_e, rdg_e, cvi_e, tw_e, acc, wrg_e;
      busy_e = (m_phase == 1 || m_phase == 2);
      done_e = (m_phase == 3 && !abort);
      pass_e = busy_e ? m_pass : 0;
      rd_e   = (m_phase == 1);
      rdg_e  = rd_e ? m_nread : 0;
      cvi_e  = q_en[0];
      tw_e   = q_grp[0];
      acc    = (core_vld_out && m_quiet == 0 && busy_e && m_nwrite < 8);
      wrg_e  = m_nwrite % 8;

      cmp("busy", busy, busy_e);
      cmp("done", done, done_e);
      cmp("pass", pass, pass_e);
      cmp("rd_en", rd_en, rd_e);
      cmp("rd_grp", rd_grp, rdg_e);
      cmp("core_vld_in", core_vld_in, cvi_e);
      cmp("tw_grp", tw_grp, tw_e);
      cmp("wr_en", wr_en, acc);
      cmp("wr_grp", wr_grp, wrg_e);
      cmp("err", err, m_err);

      if (cyc < 512) begin
        h_busy[cyc] = busy;  h_done[cyc] = done;  h_pass[cyc] = pass;
        h_rd[cyc]   = rd_en; h_cvi[cyc]  = core_vld_in;
        h_wr[cyc]   = wr_en; h_err[cyc]  = err;
        h_rdg[cyc]  = rd_grp; h_wrg[cyc] = wr_grp;
        h3_rd[cyc]  = rd_en3; h3_cvi[cyc] = core_vld_in3;
        h3_wr[cyc]  = wr_en3; h3_done[cyc] = done3;
      end

      if (rst) begin
        m_phase = 0; m_pass = 0; m_nread = 0; m_nwrite = 0;
        m_quiet = 0; m_err = 0;
        model_clear_pipe();
      end else begin
        if (core_vld_out && m_quiet == 0 && !acc) m_err = 1;
        if (m_quiet > 0) m_quiet--;
        q_en.push_back(rd_e);
        q_grp.push_back(rdg_e);
        void'(q_en.pop_front());
        void'(q_grp.pop_front());
        if (acc) m_nwrite++;
        if (abort && m_phase != 0) begin
          m_phase = 0; m_pass = 0; m_nread = 0; m_nwrite = 0;
          m_quiet = 2 + M_LAT;
          model_clear_pipe();
        end else begin
          case (m_phase)
            0: if (start) begin m_phase = 1; m_pass = 0; end
            1: begin
              m_nread++;
              if (m_nread == 8) begin m_nread = 0; m_phase = 2; end
            end
            2: if (m_nwrite == 8) begin
              m_nwrite = 0;
              if (m_pass == 0) begin m_pass = 1; m_phase = 1; end
              else m_phase = 3;
            end
            default: begin m_phase = 0; m_pass = 0; end
          endcase
        end
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int count_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(h_done[i]);
    return c;
  endfunction

  initial begin
    rst = 1; start = 0; abort = 0; inj = 0;
    rst3 = 1; start3 = 0;
    model_clear_pipe();

    goto(3);  rst = 0; rst3 = 0;
    // Nominal run at 10, start during busy at 15, start at done (33) and idle (34)
    goto(10); start = 1;
    goto(11); start = 0;
    goto(15); start = 1;
    goto(16); start = 0;
    goto(33); start = 1;
    goto(35); start = 0;
    // Abort in RD1
    goto(70); start = 1;
    goto(71); start = 0;
    goto(84); abort = 1;
    goto(85); abort = 0; inj = 1;
    goto(88); inj = 0;
    goto(100); start = 1;
    goto(101); start = 0;
    // Protocol error in IDLE, then full run with err held, then rst clears it
    goto(130); inj = 1;
    goto(131); inj = 0;
    goto(135); start = 1;
    goto(136); start = 0;
    goto(160); rst = 1;
    goto(161); rst = 0;
    // Reset mid-transform, stray valids after reset, then nominal run
    goto(165); start = 1;
    goto(166); start = 0;
    goto(171); rst = 1;
    goto(172); rst = 0; inj = 1;
    goto(174); inj = 0;
    goto(180); start = 1;
    goto(181); start = 0;
    // RD_LAT = 3 instance
    goto(215); start3 = 1;
    goto(216); start3 = 0;
    goto(250);

    // Nominal timing, start at 10
    cmp("nom_rd_first",  h_rd[11], 1);
    cmp("nom_cvi_pre",   h_cvi[11], 0);
    cmp("nom_cvi_first", h_cvi[12], 1);
    cmp("nom_wr_pre",    h_wr[13], 0);
    cmp("nom_wr_first",  h_wr[14], 1);
    cmp("nom_rdg_last",  h_rdg[18], 7);
    cmp("nom_rd_end",    h_rd[19], 0);
    cmp("nom_wrg_last0", h_wrg[21], 7);
    cmp("nom_wr_last0",  h_wr[21], 1);
    cmp("nom_rd1_first", h_rd[22], 1);
    cmp("nom_pass1",     h_pass[22], 1);
    cmp("nom_wr_last1",  h_wr[32], 1);
    cmp("nom_done_pre",  h_done[32], 0);
    cmp("nom_done",      h_done[33], 1);
    cmp("nom_busy_done", h_busy[33], 0);
    cmp("nom_done_cnt",  count_done(10, 56), 1);
    // Back-to-back
    cmp("b2b_idle",      h_busy[34], 0);
    cmp("b2b_busy",      h_busy[35], 1);
    cmp("b2b_done",      h_done[57], 1);
    // Abort
    cmp("abt_idle",      h_busy[85], 0);
    cmp("abt_err",       h_err[90], 0);
    cmp("abt_no_done",   count_done(71, 99), 0);
    cmp("abt_rerun",     h_done[123], 1);
    // Protocol error
    cmp("perr_wr",       h_wr[130], 0);
    cmp("perr_err",      h_err[131], 1);
    cmp("perr_hold",     h_err[158], 1);
    cmp("perr_done",     h_done[158], 1);
    cmp("perr_rst",      h_err[161], 0);
    // Reset mid-transform
    cmp("rst_busy",      h_busy[172], 0);
    cmp("rst_rd",        h_rd[172], 0);
    cmp("rst_cvi",       h_cvi[172], 0);
    cmp("rst_err0",      h_err[172], 0);
    cmp("rst_err1",      h_err[173], 1);
    cmp("rst_no_done",   count_done(166, 179), 0);
    cmp("rst_rerun",     h_done[203], 1);
    // RD_LAT = 3, start at 215
    cmp("l3_rd_first",   h3_rd[216], 1);
    cmp("l3_cvi_pre",    h3_cvi[218], 0);
    cmp("l3_cvi_first",  h3_cvi[219], 1);
    cmp("l3_wr_last0",   h3_wr[228], 1);
    cmp("l3_rd1_pre",    h3_rd[228], 0);
    cmp("l3_rd1_first",  h3_rd[229], 1);
    cmp("l3_done_pre",   h3_done[241], 0);
    cmp("l3_done",       h3_done[242], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
